// File: rtl/ysyx_25040111_axi_arbiter_pkg.sv
// Shared types and AXI constants for the IFU/LSU arbiter onto the core's single AXI4 master port.
package ysyx_25040111_axi_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_AW,
      ST_WR_B
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam int         ID_W       = 4;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_B     = 3'b000;
   localparam logic [2:0] SIZE_H     = 3'b001;
   localparam logic [2:0] SIZE_W     = 3'b010;

endpackage

// File: rtl/ysyx_25040111_axi_arbiter_if.sv
// AXI4 master-port bundle (single-beat subset) between the arbiter and the SoC bus.
interface ysyx_25040111_axi_arbiter_if
   import ysyx_25040111_axi_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                awvalid;
   logic                awready;
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awsize;
   logic [ID_W-1:0]     awid;
   logic [7:0]          awlen;
   logic [1:0]          awburst;

   logic                wvalid;
   logic                wready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;

   logic                bready;
   logic                bvalid;
   logic [1:0]          bresp;
   logic [ID_W-1:0]     bid;

   logic                arvalid;
   logic                arready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arsize;
   logic [ID_W-1:0]     arid;
   logic [7:0]          arlen;
   logic [1:0]          arburst;

   logic                rready;
   logic                rvalid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic [ID_W-1:0]     rid;

   modport master (
      output awvalid, awaddr, awsize, awid, awlen, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      output bready,
      input  bvalid, bresp, bid,
      output arvalid, araddr, arsize, arid, arlen, arburst,
      input  arready,
      output rready,
      input  rvalid, rdata, rresp, rlast, rid
   );

   modport slave (
      input  awvalid, awaddr, awsize, awid, awlen, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      input  bready,
      output bvalid, bresp, bid,
      input  arvalid, araddr, arsize, arid, arlen, arburst,
      output arready,
      input  rready,
      output rvalid, rdata, rresp, rlast, rid
   );

endinterface

// File: rtl/ysyx_25040111_rr_arb2.sv
// Two-way IFU/LSU grant: round-robin against the last winner, or fixed LSU priority when RR_EN=0.
module ysyx_25040111_rr_arb2
   import ysyx_25040111_axi_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   req_ifu,
   input  logic   req_lsu,
   input  logic   take,
   output logic   valid,
   output owner_e gnt
);

   owner_e last_gnt;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      valid = req_ifu | req_lsu;
      gnt   = OWN_IFU;
      if (req_ifu && req_lsu) begin
         if (!RR_EN || last_gnt == OWN_IFU) gnt = OWN_LSU;
         else                               gnt = OWN_IFU;
      end else if (req_lsu) begin
         gnt = OWN_LSU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               last_gnt <= OWN_IFU;
      else if (take && valid) last_gnt <= gnt;
   end

endmodule

// File: rtl/ysyx_25040111_axi_arbiter.sv
// Shares one AXI4 master port between the IFU (reads) and the LSU (reads/writes),
// turning each req/done handshake into a single-beat AXI transaction.
module ysyx_25040111_axi_arbiter
   import ysyx_25040111_axi_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter bit RR_EN  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ifu_req,
   input  logic [ADDR_W-1:0]      ifu_addr,
   output logic                   ifu_done,
   output logic [DATA_W-1:0]      ifu_rdata,
   output logic [1:0]             ifu_resp,
   input  logic                   lsu_req,
   input  logic                   lsu_we,
   input  logic [ADDR_W-1:0]      lsu_addr,
   input  logic [2:0]             lsu_size,
   input  logic [DATA_W-1:0]      lsu_wdata,
   input  logic [DATA_W/8-1:0]    lsu_wstrb,
   output logic                   lsu_done,
   output logic [DATA_W-1:0]      lsu_rdata,
   output logic [1:0]             lsu_resp,
   ysyx_25040111_axi_arbiter_if.master io_master
);

   state_e              state, state_nxt;
   owner_e              owner, arb_gnt;
   logic                arb_valid, grant;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          size_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                aw_ok, w_ok;
   logic                aw_hs, w_hs, ar_hs, r_hs, b_hs;
   logic                unused_ids;

   assign grant = (state == ST_IDLE) && arb_valid;

   ysyx_25040111_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_ifu (ifu_req),
      .req_lsu (lsu_req),
      .take    (grant),
      .valid   (arb_valid),
      .gnt     (arb_gnt)
   );

   // Valids derive from state and completion flags, so payloads hold until their own handshake.
   assign io_master.arvalid = (state == ST_RD_A);
   assign io_master.araddr  = addr_q;
   assign io_master.arsize  = size_q;
   assign io_master.arid    = '0;
   assign io_master.arlen   = '0;
   assign io_master.arburst = BURST_INCR;
   assign io_master.rready  = (state == ST_RD_D);
   assign io_master.awvalid = (state == ST_WR_AW) && !aw_ok;
   assign io_master.awaddr  = addr_q;
   assign io_master.awsize  = size_q;
   assign io_master.awid    = '0;
   assign io_master.awlen   = '0;
   assign io_master.awburst = BURST_INCR;
   assign io_master.wvalid  = (state == ST_WR_AW) && !w_ok;
   assign io_master.wdata   = wdata_q;
   assign io_master.wstrb   = wstrb_q;
   assign io_master.wlast   = (state == ST_WR_AW) && !w_ok;
   assign io_master.bready  = (state == ST_WR_B);

   assign ar_hs = io_master.arvalid && io_master.arready;
   assign r_hs  = io_master.rready  && io_master.rvalid;
   assign aw_hs = io_master.awvalid && io_master.awready;
   assign w_hs  = io_master.wvalid  && io_master.wready;
   assign b_hs  = io_master.bready  && io_master.bvalid;

   // Single outstanding transaction with len=0, so ids and rlast carry no information.
   assign unused_ids = ^{io_master.bid, io_master.rid, io_master.rlast};

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (arb_valid) begin
               if (arb_gnt == OWN_LSU && lsu_we) state_nxt = ST_WR_AW;
               else                              state_nxt = ST_RD_A;
            end
         end
         ST_RD_A:  if (ar_hs) state_nxt = ST_RD_D;
         ST_RD_D:  if (r_hs)  state_nxt = ST_IDLE;
         ST_WR_AW: if ((aw_ok || aw_hs) && (w_ok || w_hs)) state_nxt = ST_WR_B;
         ST_WR_B:  if (b_hs)  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= OWN_IFU;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_ok     <= 1'b0;
         w_ok      <= 1'b0;
         ifu_done  <= 1'b0;
         ifu_rdata <= '0;
         ifu_resp  <= '0;
         lsu_done  <= 1'b0;
         lsu_rdata <= '0;
         lsu_resp  <= '0;
      end else begin
         ifu_done <= 1'b0;
         lsu_done <= 1'b0;
         if (grant) begin
            owner <= arb_gnt;
            aw_ok <= 1'b0;
            w_ok  <= 1'b0;
            if (arb_gnt == OWN_LSU) begin
               addr_q  <= lsu_addr;
               size_q  <= lsu_size;
               wdata_q <= lsu_wdata;
               wstrb_q <= lsu_wstrb;
            end else begin
               addr_q  <= ifu_addr;
               size_q  <= SIZE_W;
            end
         end
         if (aw_hs) aw_ok <= 1'b1;
         if (w_hs)  w_ok  <= 1'b1;
         if (r_hs) begin
            if (owner == OWN_IFU) begin
               ifu_rdata <= io_master.rdata;
               ifu_resp  <= io_master.rresp;
               ifu_done  <= 1'b1;
            end else begin
               lsu_rdata <= io_master.rdata;
               lsu_resp  <= io_master.rresp;
               lsu_done  <= 1'b1;
            end
         end
         if (b_hs) begin
            lsu_resp <= io_master.bresp;
            lsu_done <= 1'b1;
         end
      end
   end

endmodule
